// File: rtl/stream_max_reduce.sv
// stream_max_reduce: two-stage running-max reducer (lane tree, then accumulator) for the softmax max stage.
// Define MAX_INDEX_EN to add out_index, the flat element position of the reported maximum.
module stream_max_reduce #(
    parameter int DATAWIDTH = 16,
    parameter int EXPWIDTH  = 5,
    parameter int NUM_LANES = 4,
    parameter int LEN_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           vec_len,
    input  logic                           seed_en,
    input  logic [DATAWIDTH-1:0]           seed_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*DATAWIDTH-1:0] in_data,
    input  logic [NUM_LANES-1:0]           in_mask,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATAWIDTH-1:0]           out_data,
`ifdef MAX_INDEX_EN
    output logic [LEN_WIDTH+$clog2(NUM_LANES)-1:0] out_index,
`endif
    output logic                           busy
);

    localparam int MANT_W = DATAWIDTH - 1 - EXPWIDTH;
    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int LEVELS = LANE_W;
    localparam logic [DATAWIDTH-1:0] NEG_INF = {1'b1, {EXPWIDTH{1'b1}}, {MANT_W{1'b0}}};
    localparam logic [DATAWIDTH-1:0] MSB_ONE = {1'b1, {(DATAWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 in_fire;
    logic                 s1_valid;
    logic [DATAWIDTH-1:0] s1_val;
    logic [DATAWIDTH-1:0] acc;
    logic [DATAWIDTH-1:0] tree_val;
    logic [DATAWIDTH-1:0] lvl_val [LEVELS+1][NUM_LANES];
`ifdef MAX_INDEX_EN
    localparam int IDX_W = LEN_WIDTH + LANE_W;
    logic [LANE_W-1:0]    lvl_idx [LEVELS+1][NUM_LANES];
    logic [LANE_W-1:0]    tree_idx;
    logic [LEN_WIDTH-1:0] beat_num;
    logic [IDX_W-1:0]     s1_idx;
    logic [IDX_W-1:0]     acc_idx;
`endif

    // Sign-magnitude to unsigned order key; -0 is folded onto +0 so both compare equal.
    function automatic logic [DATAWIDTH-1:0] order_key(input logic [DATAWIDTH-1:0] x);
        logic [DATAWIDTH-1:0] k;
        if (x == MSB_ONE)
            k = MSB_ONE;
        else if (x[DATAWIDTH-1])
            k = ~x;
        else
            k = x ^ MSB_ONE;
        return k;
    endfunction

    // True only when b strictly beats a, so ties keep the earlier operand.
    function automatic logic beats(input logic [DATAWIDTH-1:0] b, input logic [DATAWIDTH-1:0] a);
        return order_key(b) > order_key(a);
    endfunction

    assign in_fire = in_valid && in_ready;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lvl_val[l][i] = '0;
`ifdef MAX_INDEX_EN
                lvl_idx[l][i] = '0;
`endif
            end
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            lvl_val[0][i] = in_mask[i] ? in_data[i*DATAWIDTH +: DATAWIDTH] : NEG_INF;
`ifdef MAX_INDEX_EN
            lvl_idx[0][i] = LANE_W'(i);
`endif
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < (NUM_LANES >> (l + 1)); i++) begin
                if (beats(lvl_val[l][2*i+1], lvl_val[l][2*i])) begin
                    lvl_val[l+1][i] = lvl_val[l][2*i+1];
`ifdef MAX_INDEX_EN
                    lvl_idx[l+1][i] = lvl_idx[l][2*i+1];
`endif
                end else begin
                    lvl_val[l+1][i] = lvl_val[l][2*i];
`ifdef MAX_INDEX_EN
                    lvl_idx[l+1][i] = lvl_idx[l][2*i];
`endif
                end
            end
        end
        tree_val = lvl_val[LEVELS][0];
`ifdef MAX_INDEX_EN
        tree_idx = lvl_idx[LEVELS][0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (vec_len == '0) ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (in_fire && cnt == LEN_WIDTH'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (!s1_valid) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_ACCUM);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        out_data  = (state == S_DONE) ? acc : '0;
`ifdef MAX_INDEX_EN
        out_index = (state == S_DONE) ? acc_idx : '0;
`endif
    end

    // Remaining beats; only decremented on a handshake so in_valid gaps cost nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (state == S_IDLE && start)
            cnt <= vec_len;
        else if (in_fire)
            cnt <= cnt - LEN_WIDTH'(1);
    end

    // Stage 1: register the per-beat tree winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire)
                s1_val <= tree_val;
        end
    end

    // Stage 2: fold the beat winner into the accumulator; the accumulator wins ties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acc <= '0;
        else if (state == S_IDLE && start)
            acc <= seed_en ? seed_data : NEG_INF;
        else if (s1_valid && beats(s1_val, acc))
            acc <= s1_val;
    end

`ifdef MAX_INDEX_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_num <= '0;
            s1_idx   <= '0;
            acc_idx  <= '0;
        end else begin
            if (state == S_IDLE && start)
                beat_num <= '0;
            else if (in_fire)
                beat_num <= beat_num + LEN_WIDTH'(1);
            if (in_fire)
                s1_idx <= {beat_num, tree_idx};
            if (state == S_IDLE && start)
                acc_idx <= '1;
            else if (s1_valid && beats(s1_val, acc))
                acc_idx <= s1_idx;
        end
    end
`endif

endmodule

// File: tb/tb_stream_max_reduce.sv
// Self-checking bench for stream_max_reduce: table vectors, corner sequences and a random sweep vs a scan model.
// Also exercises out_index when MAX_INDEX_EN is defined.
module tb_stream_max_reduce;

    localparam logic [15:0] NEG_INF = 16'hFC00;
    localparam logic [17:0] NO_IDX  = 18'h3FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] vec_len = '0;
    logic        seed_en = 1'b0;
    logic [15:0] seed_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [3:0]  in_mask = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;
`ifdef MAX_INDEX_EN
    logic [17:0] out_index;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] vb_data[$];
    logic [3:0]  vb_mask[$];

    typedef struct packed {
        bit              sen;
        logic [15:0]     sd;
        int              len;
        int              gap;
        logic [3:0][63:0] d;
        logic [3:0][3:0]  m;
        logic [15:0]     ev;
        logic [17:0]     ei;
    } vec_t;

    vec_t tbl [10];

    stream_max_reduce dut (
        .clk(clk), .reset_n(reset_n), .start(start), .vec_len(vec_len),
        .seed_en(seed_en), .seed_data(seed_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MAX_INDEX_EN
        .out_index(out_index),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mkey(input logic [15:0] x);
        if (x == 16'h8000) return 16'h8000;
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

    // Flat scan in element order; strict compare keeps the earliest of equal keys.
    task automatic ref_model(input bit sen, input logic [15:0] sd, input int len,
                             output logic [15:0] mv, output logic [17:0] mi);
        logic [15:0] v;
        mv = sen ? sd : NEG_INF;
        mi = NO_IDX;
        for (int b = 0; b < len; b++) begin
            for (int l = 0; l < 4; l++) begin
                v = vb_mask[b][l] ? vb_data[b][l*16 +: 16] : NEG_INF;
                if (mkey(v) > mkey(mv)) begin
                    mv = v;
                    mi = 18'(b * 4 + l);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input vec_t e);
        vb_data.delete();
        vb_mask.delete();
        for (int b = 0; b < 4; b++) begin
            vb_data.push_back(e.d[b]);
            vb_mask.push_back(e.m[b]);
        end
    endtask

    task automatic run_vec(input string tag, input bit sen, input logic [15:0] sd, input int len,
                           input int gap_pct, input logic [15:0] exp_val, input logic [17:0] exp_idx);
        int  sent;
        int  cyc;
        int  extra;
        int  wait_n;
        bit  hs;
        start = 1'b1;
        vec_len = 16'(len);
        seed_en = sen;
        seed_data = sd;
        step();
        start = 1'b0;
        sent = 0;
        cyc = 0;
        while (sent < len && cyc < 2000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data = vb_data[sent];
            in_mask = vb_mask[sent];
            hs = in_valid && in_ready;
            step();
            cyc++;
            if (hs) sent++;
        end
        check({tag, " handshakes"}, sent, len);
        check({tag, " ready_low"}, in_ready, 1'b0);
        // Offer a large poison beat during the drain; it must never be accepted.
        in_valid = 1'b1;
        in_data = {4{16'h7BFF}};
        in_mask = 4'hF;
        extra = 0;
        wait_n = 0;
        while (!out_valid && wait_n < 50) begin
            if (in_ready) extra++;
            step();
            wait_n++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, wait_n, (len == 0) ? 1 : 2);
        check({tag, " extra_beats"}, extra, 0);
        check({tag, " out_data"}, out_data, exp_val);
`ifdef MAX_INDEX_EN
        check({tag, " out_index"}, out_index, exp_idx);
`else
        if (exp_idx == 18'h0 && out_index_absent()) begin end
`endif
    endtask

    function automatic bit out_index_absent();
        return 1'b1;
    endfunction

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " back_to_idle"}, {out_valid, busy}, 2'b00);
    endtask

    function automatic vec_t mk(input bit sen, input logic [15:0] sd, input int len, input int gap,
                                input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                                input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2,
                                input logic [15:0] ev, input logic [17:0] ei);
        vec_t e;
        e.sen = sen; e.sd = sd; e.len = len; e.gap = gap;
        e.d[0] = d0; e.d[1] = d1; e.d[2] = d2; e.d[3] = '0;
        e.m[0] = m0; e.m[1] = m1; e.m[2] = m2; e.m[3] = 4'hF;
        e.ev = ev; e.ei = ei;
        return e;
    endfunction

    function automatic logic [15:0] rand_val();
        logic [15:0] pick [8];
        pick = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, NEG_INF, 16'h7C00, 16'h7BFF, 16'hFBFF};
        if ($urandom_range(3) == 0) return pick[$urandom_range(7)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [15:0] mv;
        logic [17:0] mi;
        int          rlen;
        bit          rsen;
        logic [15:0] rsd;
        logic [63:0] beat;

        // {lane3, lane2, lane1, lane0}
        tbl[0] = mk(0, 16'h0, 1, 0,  {16'h3800, 16'hBC00, 16'h4000, 16'h3C00}, '0, '0,
                    4'hF, 4'hF, 4'hF, 16'h4000, 18'd1);
        tbl[1] = mk(0, 16'h0, 3, 40, {16'h4200, 16'h3C00, 16'h0000, 16'hBC00},
                    {16'h4000, 16'h4500, 16'hC400, 16'h0000}, {16'hC000, 16'hC200, 16'hC400, 16'hC800},
                    4'hF, 4'hF, 4'hF, 16'h4500, 18'd6);
        tbl[2] = mk(1, 16'h4800, 2, 0, {16'h4400, 16'h4000, 16'h3C00, 16'h0000},
                    {16'h4200, 16'h4100, 16'hC000, 16'h4400}, '0, 4'hF, 4'hF, 4'hF, 16'h4800, NO_IDX);
        tbl[3] = mk(0, 16'h4800, 2, 0, {16'h4400, 16'h4000, 16'h3C00, 16'h0000},
                    {16'h4200, 16'h4100, 16'hC000, 16'h4400}, '0, 4'hF, 4'hF, 4'hF, 16'h4400, 18'd3);
        tbl[4] = mk(0, 16'h0, 1, 0, {16'h7BFF, 16'h7BFF, 16'h7BFF, 16'h0000}, '0, '0,
                    4'b0001, 4'hF, 4'hF, 16'h0000, 18'd0);
        tbl[5] = mk(0, 16'h0, 0, 0, '0, '0, '0, 4'hF, 4'hF, 4'hF, NEG_INF, NO_IDX);
        tbl[6] = mk(0, 16'h0, 1, 0, {4{16'h7BFF}}, '0, '0, 4'h0, 4'hF, 4'hF, NEG_INF, NO_IDX);
        tbl[7] = mk(0, 16'h0, 1, 0, {16'hC000, 16'hC000, 16'h0000, 16'h8000}, '0, '0,
                    4'hF, 4'hF, 4'hF, 16'h8000, 18'd0);
        tbl[8] = mk(0, 16'h0, 3, 30, {4{16'h3C00}}, {4{16'h4000}}, {16'h5000, 16'h4800, 16'h4800, 16'h4800},
                    4'hF, 4'hF, 4'hF, 16'h5000, 18'd11);
        tbl[9] = mk(1, 16'h3C00, 2, 0, {4{16'h7BFF}}, {4{16'h7800}}, '0, 4'h0, 4'h0, 4'hF, 16'h3C00, NO_IDX);

        // Reset state
        #12;
        check("reset outputs", {in_ready, out_valid, busy, out_data}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post-reset idle", {in_ready, out_valid, busy}, 3'b000);

        for (int k = 0; k < 10; k++) begin
            load_entry(tbl[k]);
            run_vec($sformatf("tbl%0d", k), tbl[k].sen, tbl[k].sd, tbl[k].len, tbl[k].gap,
                    tbl[k].ev, tbl[k].ei);
            release_out($sformatf("tbl%0d", k));
        end

        // Backpressure: result held for 5 cycles while start pulses are ignored.
        load_entry(tbl[1]);
        run_vec("hold", 0, 16'h0, 3, 0, 16'h4500, 18'd6);
        for (int c = 0; c < 5; c++) begin
            start = $urandom_range(1);
            vec_len = 16'($urandom_range(1, 5));
            seed_en = 1'b1;
            seed_data = 16'h7000;
            step();
            check($sformatf("hold c%0d valid", c), out_valid, 1'b1);
            check($sformatf("hold c%0d data", c), out_data, 16'h4500);
        end
        start = 1'b0;
        release_out("hold");
        load_entry(tbl[8]);
        run_vec("after_hold", 0, 16'h0, 3, 0, 16'h5000, 18'd11);
        release_out("after_hold");

        // Reset mid-vector aborts it.
        load_entry(tbl[8]);
        start = 1'b1;
        vec_len = 16'd4;
        seed_en = 1'b0;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = {4{16'h7000}};
        in_mask = 4'hF;
        step();
        step();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset outputs", {in_ready, out_valid, busy, out_data}, '0);
        step();
        reset_n = 1'b1;
        step();
        check("midreset idle", {out_valid, busy}, 2'b00);
        load_entry(tbl[1]);
        run_vec("after_reset", 0, 16'h0, 3, 20, 16'h4500, 18'd6);
        release_out("after_reset");

        // Random sweep against the scan model.
        for (int r = 0; r < 60; r++) begin
            vb_data.delete();
            vb_mask.delete();
            rlen = $urandom_range(0, 6);
            rsen = $urandom_range(1);
            rsd = rand_val();
            for (int b = 0; b < rlen; b++) begin
                for (int l = 0; l < 4; l++) beat[l*16 +: 16] = rand_val();
                vb_data.push_back(beat);
                vb_mask.push_back(($urandom_range(3) == 0) ? 4'($urandom) : 4'hF);
            end
            ref_model(rsen, rsd, rlen, mv, mi);
            run_vec($sformatf("rnd%0d", r), rsen, rsd, rlen, $urandom_range(0, 50), mv, mi);
            release_out($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
